// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: rate-1/2, constraint-length-3 convolutional encoder
// (generators 7 and 5 octal). Two zero tail bits follow every FRAME_LEN data
// bits so the decoder trellis always terminates in state 0.
//
// Handshake: a data bit is taken on a rising edge when enable_i && ready_o.
// ready_o depends only on the FSM state (held low during rst), never on
// enable_i. valid_o qualifies d_out for exactly one cycle per symbol; the
// output side has no backpressure. d_out holds its last value while valid_o=0.
module conv_encoder_framer #(
    parameter int FRAME_LEN = 64,
    parameter int CT_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_i,
    input  logic            d_in,
    output logic            ready_o,
    output logic            valid_o,
    output logic [1:0]      d_out,
    output logic            frame_start_o,
    output logic            frame_end_o,
    output logic [CT_W-1:0] frame_ct_o,
    output logic [1:0]      state_dbg
);

    localparam int            BW      = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN + 1);
    localparam logic [BW-1:0] LAST_CT = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] bit_ct;
    logic          tail_ct;
    logic [1:0]    sr;

    logic accept;
    logic enc_en;
    logic enc_bit;
    logic start_nxt;
    logic end_nxt;

    assign ready_o   = !rst && (state != TAIL);
    assign accept    = enable_i && ready_o;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle encode request; tail cycles encode a forced 0.
    always_comb begin
        state_nxt = state;
        enc_en    = 1'b0;
        enc_bit   = d_in;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    enc_en    = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = (FRAME_LEN == 1) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    enc_en = 1'b1;
                    // bit_ct still holds the count before this accept.
                    if (bit_ct == LAST_CT) begin
                        state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                enc_en  = 1'b1;
                enc_bit = 1'b0;
                if (tail_ct) begin
                    end_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Encoder shift register, registered symbol outputs and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr            <= 2'b00;
            bit_ct        <= '0;
            tail_ct       <= 1'b0;
            valid_o       <= 1'b0;
            d_out         <= 2'b00;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            frame_ct_o    <= '0;
        end else begin
            valid_o       <= enc_en;
            frame_start_o <= start_nxt;
            frame_end_o   <= end_nxt;

            if (enc_en) begin
                d_out <= {enc_bit ^ sr[0] ^ sr[1], enc_bit ^ sr[1]};
                sr    <= {sr[0], enc_bit};
            end

            // Last tail bit: sr is already zero by construction, but clear it
            // explicitly so IDLE always starts from the zero state.
            if (end_nxt) begin
                sr         <= 2'b00;
                frame_ct_o <= frame_ct_o + CT_W'(1);
            end

            if (accept && (state == IDLE)) begin
                bit_ct <= BW'(1);
            end else if (accept && (state == DATA)) begin
                bit_ct <= bit_ct + BW'(1);
            end

            if (state == TAIL) begin
                tail_ct <= ~tail_ct;
            end else begin
                tail_ct <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: a FRAME_LEN=4/CT_W=2 instance for the main
// scenarios and a FRAME_LEN=1/CT_W=3 instance for the single-bit frame case.
// Expected symbols come from a convolution model over the frame's bit history.
module tb_conv_encoder_framer;

    localparam int FL = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          d_in;
    logic          ready_o;
    logic          valid_o;
    logic [1:0]    d_out;
    logic          frame_start_o;
    logic          frame_end_o;
    logic [CW-1:0] frame_ct_o;
    logic [1:0]    state_dbg;

    logic          en1;
    logic          d1;
    logic          rdy1;
    logic          v1;
    logic [1:0]    dout1;
    logic          fs1;
    logic          fe1;
    logic [2:0]    ct1;
    logic [1:0]    st1;

    int vectors     = 0;
    int errors      = 0;
    int cyc         = 0;
    int done        = 0;
    int notready_ct = 0;

    // Symbol record: {frame_ct, frame_end, frame_start, d_out}
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    int         exp_t[$];
    int         obs_t[$];
    int         acc_t[$];

    logic [1:0] ref_sym [6];
    bit         ref_bits[4];

    conv_encoder_framer #(.FRAME_LEN(FL), .CT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in),
        .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .frame_ct_o(frame_ct_o), .state_dbg(state_dbg)
    );

    conv_encoder_framer #(.FRAME_LEN(1), .CT_W(3)) dut1 (
        .clk(clk), .rst(rst), .enable_i(en1), .d_in(d1),
        .ready_o(rdy1), .valid_o(v1), .d_out(dout1),
        .frame_start_o(fs1), .frame_end_o(fe1),
        .frame_ct_o(ct1), .state_dbg(st1)
    );

    // Clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every emitted symbol and count non-ready cycles.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            obs_q.push_back({frame_ct_o, frame_end_o, frame_start_o, d_out});
            obs_t.push_back(cyc);
        end
        if (!rst && !ready_o) notready_ct <= notready_ct + 1;
    end

    task automatic clear_q();
        exp_q.delete(); obs_q.delete();
        exp_t.delete(); obs_t.delete(); acc_t.delete();
    endtask

    // Reference model: symbol k = {h[k]^h[k-1]^h[k-2], h[k]^h[k-2]} over the
    // history 0,0,data...,0,0; counter advances with the final tail symbol.
    task automatic model_frame(input bit bq[$]);
        bit h[$];
        int n;
        h.push_back(1'b0);
        h.push_back(1'b0);
        foreach (bq[i]) h.push_back(bq[i]);
        h.push_back(1'b0);
        h.push_back(1'b0);
        n = h.size();
        for (int k = 2; k < n; k++) begin
            logic       last;
            logic [1:0] c;
            last = (k == n - 1);
            c    = last ? 2'(done + 1) : 2'(done);
            exp_q.push_back({c, last, (k == 2), h[k] ^ h[k-1] ^ h[k-2], h[k] ^ h[k-2]});
        end
        done++;
    endtask

    // Driver: idle for gap cycles, then present b until it is accepted.
    task automatic send_bit(input bit b, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            enable_i = 1'b0;
        end
        @(negedge clk);
        enable_i = 1'b1;
        d_in     = b;
        guard    = 0;
        while (ready_o !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            errors++;
            $display("FAIL send_timeout ready_o got %b want 1", ready_o);
        end
        acc_t.push_back(cyc + 1);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        enable_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({valid_o, d_out, frame_start_o, frame_end_o, frame_ct_o, ready_o, state_dbg} !== 10'b0) begin
            errors++;
            $display("FAIL reset_values got v=%b d=%b fs=%b fe=%b ct=%0d rdy=%b st=%0d want all 0",
                     valid_o, d_out, frame_start_o, frame_end_o, frame_ct_o, ready_o, state_dbg);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (ready_o !== 1'b1 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b/%b want 1/1", ready_o, rdy1);
        end
    endtask

    task automatic test_basic();
        int nr0;
        clear_q();
        nr0 = notready_ct;
        for (int i = 0; i < 4; i++) send_bit(ref_bits[i], 0);
        finish_frame();
        for (int i = 0; i < 6; i++)
            exp_q.push_back({2'(done + ((i == 5) ? 1 : 0)), (i == 5), (i == 0), ref_sym[i]});
        done++;
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_sym[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (notready_ct - nr0 !== 2) begin
            errors++;
            $display("FAIL basic_notready got %0d want 2", notready_ct - nr0);
        end
    endtask

    task automatic test_gaps();
        int gaps[4];
        bit bq[$];
        int last;
        gaps = '{0, 2, 1, 3};
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bq.push_back(ref_bits[i]);
            send_bit(ref_bits[i], gaps[i]);
        end
        finish_frame();
        model_frame(bq);
        foreach (acc_t[i]) exp_t.push_back(acc_t[i]);
        last = acc_t[acc_t.size() - 1];
        exp_t.push_back(last + 1);
        exp_t.push_back(last + 2);
        vectors++;
        if (obs_q.size() !== exp_q.size() || obs_t.size() !== exp_t.size()) begin
            errors++;
            $display("FAIL gaps_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size() && i < obs_t.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL gaps_sym[%0d] got %b@%0d want %b@%0d",
                         i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_hold_tail();
        bit qa[$];
        bit qb[$];
        clear_q();
        for (int i = 0; i < FL; i++) begin
            qa.push_back(1'($urandom_range(0, 1)));
            qb.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < FL; i++) send_bit(qa[i], 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            enable_i = 1'b1;
            d_in     = 1'($urandom_range(0, 1));
            vectors++;
            if (ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_tail_ready[%0d] got %b want 0", i, ready_o);
            end
        end
        for (int i = 0; i < FL; i++) send_bit(qb[i], 0);
        finish_frame();
        model_frame(qa);
        model_frame(qb);
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL hold_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hold_sym[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        enable_i = 1'b0;
        rst      = 1'b1;
        #1;
        vectors++;
        if ({valid_o, d_out, frame_start_o, frame_end_o, frame_ct_o, ready_o, state_dbg} !== 10'b0) begin
            errors++;
            $display("FAIL midrst_values got v=%b d=%b fs=%b fe=%b ct=%0d rdy=%b st=%0d want all 0",
                     valid_o, d_out, frame_start_o, frame_end_o, frame_ct_o, ready_o, state_dbg);
        end
        @(negedge clk);
        rst  = 1'b0;
        done = 0;
        clear_q();
        for (int i = 0; i < 4; i++) send_bit(ref_bits[i], 0);
        finish_frame();
        for (int i = 0; i < 6; i++)
            exp_q.push_back({2'((i == 5) ? 1 : 0), (i == 5), (i == 0), ref_sym[i]});
        done++;
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_sym[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] want[5];
        logic [1:0] ends[$];
        want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        done = 0;
        clear_q();
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < FL; i++) send_bit(1'($urandom_range(0, 1)), 0);
        finish_frame();
        foreach (obs_q[i]) if (obs_q[i][3]) ends.push_back(obs_q[i][5:4]);
        done = 5;
        vectors++;
        if (ends.size() !== 5) begin
            errors++;
            $display("FAIL wrap_count got %0d want 5", ends.size());
        end
        for (int i = 0; i < 5 && i < ends.size(); i++) begin
            vectors++;
            if (ends[i] !== want[i]) begin
                errors++;
                $display("FAIL wrap_ct[%0d] got %0d want %0d", i, ends[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int f = 0; f < 30; f++) begin
            bit bq[$];
            for (int i = 0; i < FL; i++) bq.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < FL; i++) send_bit(bq[i], int'($urandom_range(0, 2)));
            model_frame(bq);
        end
        finish_frame();
        vectors++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_sym[%0d] got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // FRAME_LEN=1: start, tail, tail+end back to back; start and end never share a symbol.
    task automatic test_frame_len1();
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            bit b;
            b   = 1'($urandom_range(0, 1));
            en1 = 1'b1;
            d1  = b;
            vectors++;
            if (rdy1 !== 1'b1) begin
                errors++;
                $display("FAIL len1_ready[%0d] got %b want 1", f, rdy1);
            end
            @(negedge clk);
            d1 = ~b;
            vectors++;
            if ({v1, fs1, fe1, dout1, rdy1} !== {3'b110, b, b, 1'b0}) begin
                errors++;
                $display("FAIL len1_first[%0d] got %b want %b", f, {v1, fs1, fe1, dout1, rdy1}, {3'b110, b, b, 1'b0});
            end
            @(negedge clk);
            vectors++;
            if ({v1, fs1, fe1, dout1, rdy1} !== {3'b100, b, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL len1_tail1[%0d] got %b want %b", f, {v1, fs1, fe1, dout1, rdy1}, {3'b100, b, 1'b0, 1'b0});
            end
            @(negedge clk);
            vectors++;
            if ({v1, fs1, fe1, dout1, ct1} !== {3'b101, b, b, 3'(f + 1)}) begin
                errors++;
                $display("FAIL len1_tail2[%0d] got %b want %b", f, {v1, fs1, fe1, dout1, ct1}, {3'b101, b, b, 3'(f + 1)});
            end
        end
        en1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        enable_i = 1'b0;
        d_in     = 1'b0;
        en1      = 1'b0;
        d1       = 1'b0;
        ref_sym  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        ref_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        test_reset();
        test_basic();
        test_gaps();
        test_hold_tail();
        test_mid_reset();
        test_wrap();
        test_random();
        test_frame_len1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
